// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Contents: md_op encodings, FSM state encoding, default latencies,
// and the quotient fill value used on divide by zero.
`timescale 1ns/1ps
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    // Quotient returned when the divisor is zero.
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result for the multiply/divide unit.
// Ports:
//   op     : operation code (md_op_e encoding)
//   a, b   : latched rs / rt operands
//   hi_res : upper product word, or remainder for divides
//   lo_res : lower product word, or quotient for divides
// Divide by zero returns quotient all-ones and remainder = dividend.
// Signed 0x8000_0000 / -1 returns quotient 0x8000_0000, remainder 0.
`timescale 1ns/1ps
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res
);

    logic [63:0] prod_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Result selection including the divide corner cases the native operators leave undefined.
    always_comb begin
        prod_s = 64'd0;
        quot_s = 32'd0;
        rem_s  = 32'd0;
        hi_res = 32'd0;
        lo_res = 32'd0;
        case (op)
            MDU_MULT: begin
                prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                hi_res = prod_s[63:32];
                lo_res = prod_s[31:0];
            end
            MDU_MULTU: begin
                prod_s = {32'd0, a} * {32'd0, b};
                hi_res = prod_s[63:32];
                lo_res = prod_s[31:0];
            end
            MDU_DIV: begin
                if (b == 32'd0) begin
                    quot_s = DIV0_LO;
                    rem_s  = a;
                end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
                    quot_s = 32'h8000_0000;
                    rem_s  = 32'd0;
                end else begin
                    quot_s = $signed(a) / $signed(b);
                    rem_s  = $signed(a) % $signed(b);
                end
                hi_res = rem_s;
                lo_res = quot_s;
            end
            MDU_DIVU: begin
                if (b == 32'd0) begin
                    quot_s = DIV0_LO;
                    rem_s  = a;
                end else begin
                    quot_s = a / b;
                    rem_s  = a % b;
                end
                hi_res = rem_s;
                lo_res = quot_s;
            end
            default: begin
                hi_res = 32'd0;
                lo_res = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_chk.sv
// Protocol checker for e_mdu: flags md/mt traffic that the D-stage stall
// logic is supposed to prevent. Holds no design state.
// Ports: clk, rst_n, start, mt_en, cancel (tie 0 when absent), busy.
`timescale 1ns/1ps
module mdu_chk (
    input logic clk,
    input logic rst_n,
    input logic start,
    input logic mt_en,
    input logic cancel,
    input logic busy
);

    a_no_start_in_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(start && busy && !cancel));

    a_no_mt_in_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(mt_en && busy && !cancel));

    a_no_start_with_mt: assert property (@(posedge clk) disable iff (!rst_n)
        !(start && mt_en && !busy && !cancel));

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit of the five-stage MIPS pipeline. Owns HI/LO,
// runs MULT/MULTU/DIV/DIVU over a fixed latency and reports busy for stalls.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, md_op    : md instruction in E and its operation
//   mt_en, mt_sel   : mthi/mtlo in E and its target (0 HI, 1 LO)
//   mf_sel          : mfhi/mflo source (0 HI, 1 LO)
//   rs_val, rt_val  : forwarded operands
//   busy            : operation in flight
//   mf_data         : combinational HI/LO read
//   hi_out, lo_out  : HI and LO registers
//   cancel          : exception flush, only when MDU_CANCEL_EN is defined
// Build option: MDU_CANCEL_EN adds the cancel input.
`timescale 1ns/1ps
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic        mt_en,
    input  logic        mt_sel,
    input  logic        mf_sel,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] mf_data,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    mdu_state_e        state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [31:0]       a_r, a_s, b_r, b_s;
    logic [1:0]        op_r, op_s;
    logic [31:0]       hi_r, hi_s, lo_r, lo_s;
    logic              busy_r;
    logic              cancel_s;
    logic [31:0]       hi_res_s, lo_res_s;

`ifdef MDU_CANCEL_EN
    assign cancel_s = cancel;
`else
    assign cancel_s = 1'b0;
`endif

    mdu_arith u_arith (
        .op     (op_r),
        .a      (a_r),
        .b      (b_r),
        .hi_res (hi_res_s),
        .lo_res (lo_res_s)
    );

    // Next-state logic: start takes priority over mt in IDLE; cancel overrides both.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        a_s     = a_r;
        b_s     = b_r;
        op_s    = op_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        case (state_r)
            S_IDLE: begin
                if (cancel_s) begin
                    state_s = S_IDLE;
                end else if (start) begin
                    a_s     = rs_val;
                    b_s     = rt_val;
                    op_s    = md_op;
                    cnt_s   = md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                    state_s = S_BUSY;
                end else if (mt_en) begin
                    if (mt_sel) begin
                        lo_s = rs_val;
                    end else begin
                        hi_s = rs_val;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cancel_s) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = S_IDLE;
                end else if (cnt_r == CNT_W'(1)) begin
                    cnt_s   = {CNT_W{1'b0}};
                    hi_s    = hi_res_s;
                    lo_s    = lo_res_s;
                    state_s = S_IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                cnt_s   = {CNT_W{1'b0}};
                state_s = S_IDLE;
            end
        endcase
    end

    // State, operand latches, counter and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            op_r    <= 2'b00;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            a_r     <= a_s;
            b_r     <= b_s;
            op_r    <= op_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            busy_r  <= (state_s == S_BUSY);
        end
    end

    assign busy    = busy_r;
    assign hi_out  = hi_r;
    assign lo_out  = lo_r;
    // No bypass: during an operation this still returns the previous HI/LO.
    assign mf_data = mf_sel ? lo_r : hi_r;

    mdu_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mt_en  (mt_en),
        .cancel (cancel_s),
        .busy   (busy_r)
    );

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu with directed vectors.
`timescale 1ns/1ps
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  md_op;
    logic        mt_en;
    logic        mt_sel;
    logic        mf_sel;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] mf_data;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    e_mdu dut (
`ifdef MDU_CANCEL_EN
        .cancel  (cancel),
`endif
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .md_op   (md_op),
        .mt_en   (mt_en),
        .mt_sel  (mt_sel),
        .mf_sel  (mf_sel),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .busy    (busy),
        .mf_data (mf_data),
        .hi_out  (hi_out),
        .lo_out  (lo_out)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    // Issue one md op at the next cycle, then count busy cycles (bounded).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        @(posedge clk); #1;
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0; rs_val = 32'hDEAD_BEEF; rt_val = 32'h0;
        n = 0;
        while (busy && n < 64) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; md_op = 2'b00; mt_en = 1'b0; mt_sel = 1'b0;
        mf_sel = 1'b0; rs_val = 32'h0; rt_val = 32'h0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        #12;
        cmp_cnt++;
        if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
        cmp_cnt++;
        if (hi_out !== 32'h0) begin err_cnt++; $display("FAIL reset_hi: got %h expected 0", hi_out); end
        cmp_cnt++;
        if (lo_out !== 32'h0) begin err_cnt++; $display("FAIL reset_lo: got %h expected 0", lo_out); end
        #11 rst_n = 1'b1;
    endtask

    task automatic test_arith();
        vec_t        v [9];
        logic [31:0] old_hi;
        int          n;
        v[0] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
        v[1] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5};
        v[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
        v[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        v[4] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        v[5] = '{2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 10};
        v[6] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        v[7] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 10};
        v[8] = '{2'b10, 32'hFFFF_FFF6, 32'h0000_0000, 32'hFFFF_FFF6, 32'hFFFF_FFFF, 10};
        old_hi = 32'h0;
        mf_sel = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            start = 1'b1; md_op = v[i].op; rs_val = v[i].a; rt_val = v[i].b;
            @(posedge clk); #1;
            start = 1'b0; rs_val = 32'hDEAD_BEEF; rt_val = 32'h0;
            cmp_cnt++;
            if (mf_data !== old_hi) begin
                err_cnt++; $display("FAIL arith%0d_mf_old: got %h expected %h", i, mf_data, old_hi);
            end
            n = 0;
            while (busy && n < 64) begin
                n++;
                @(posedge clk); #1;
            end
            cmp_cnt++;
            if (n !== v[i].lat) begin
                err_cnt++; $display("FAIL arith%0d_busy_cycles: got %0d expected %0d", i, n, v[i].lat);
            end
            cmp_cnt++;
            if (hi_out !== v[i].hi) begin
                err_cnt++; $display("FAIL arith%0d_hi: got %h expected %h", i, hi_out, v[i].hi);
            end
            cmp_cnt++;
            if (lo_out !== v[i].lo) begin
                err_cnt++; $display("FAIL arith%0d_lo: got %h expected %h", i, lo_out, v[i].lo);
            end
            old_hi = v[i].hi;
        end
    endtask

    task automatic test_mt_mf();
        @(posedge clk); #1;
        mt_en = 1'b1; mt_sel = 1'b0; rs_val = 32'h0000_1234;
        @(posedge clk); #1;
        mt_sel = 1'b1; rs_val = 32'h0000_5678;
        @(posedge clk); #1;
        mt_en = 1'b0; rs_val = 32'h0;
        mf_sel = 1'b0; #1;
        cmp_cnt++;
        if (mf_data !== 32'h0000_1234) begin err_cnt++; $display("FAIL mfhi: got %h expected 00001234", mf_data); end
        mf_sel = 1'b1; #1;
        cmp_cnt++;
        if (mf_data !== 32'h0000_5678) begin err_cnt++; $display("FAIL mflo: got %h expected 00005678", mf_data); end
        cmp_cnt++;
        if (hi_out !== 32'h0000_1234) begin err_cnt++; $display("FAIL mt_hi_kept: got %h expected 00001234", hi_out); end
        mf_sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        run_op(2'b00, 32'd2, 32'd3, n);
        cmp_cnt++;
        if (lo_out !== 32'd6) begin err_cnt++; $display("FAIL b2b_first_lo: got %h expected 6", lo_out); end
        // Start again in the very first idle cycle.
        start = 1'b1; md_op = 2'b01; rs_val = 32'd5; rt_val = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        cmp_cnt++;
        if (busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        n = 0;
        while (busy && n < 64) begin n++; @(posedge clk); #1; end
        cmp_cnt++;
        if (lo_out !== 32'd30 || n !== 5) begin
            err_cnt++; $display("FAIL b2b_second: got lo=%h n=%0d expected lo=0000001e n=5", lo_out, n);
        end
        run_op(2'b11, 32'd100, 32'd7, n);
        cmp_cnt++;
        if (lo_out !== 32'd14 || hi_out !== 32'd2) begin
            err_cnt++; $display("FAIL b2b_divu: got hi=%h lo=%h expected hi=2 lo=e", hi_out, lo_out);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        @(posedge clk); #1;
        start = 1'b1; md_op = 2'b10; rs_val = 32'd1000; rt_val = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if (busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        cmp_cnt++;
        if (hi_out !== 32'h0 || lo_out !== 32'h0) begin
            err_cnt++; $display("FAIL rstmid_hilo: got hi=%h lo=%h expected 0/0", hi_out, lo_out);
        end
        #2 rst_n = 1'b1;
        run_op(2'b00, 32'd2, 32'd3, n);
        cmp_cnt++;
        if (lo_out !== 32'd6 || hi_out !== 32'd0) begin
            err_cnt++; $display("FAIL rstmid_after: got hi=%h lo=%h expected 0/6", hi_out, lo_out);
        end
    endtask

`ifdef MDU_CANCEL_EN
    task automatic test_cancel();
        @(posedge clk); #1;
        mt_en = 1'b1; mt_sel = 1'b0; rs_val = 32'hAA;
        @(posedge clk); #1;
        mt_sel = 1'b1;
        @(posedge clk); #1;
        mt_en = 1'b0;
        start = 1'b1; md_op = 2'b10; rs_val = 32'd100; rt_val = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin @(posedge clk); #1; end
        cancel = 1'b1; start = 1'b1; md_op = 2'b00; rs_val = 32'd2; rt_val = 32'd3;
        @(posedge clk); #1;
        cancel = 1'b0; start = 1'b0;
        cmp_cnt++;
        if (busy !== 1'b0) begin err_cnt++; $display("FAIL cancel_busy: got %b expected 0", busy); end
        cmp_cnt++;
        if (hi_out !== 32'hAA || lo_out !== 32'hAA) begin
            err_cnt++; $display("FAIL cancel_hilo: got hi=%h lo=%h expected aa/aa", hi_out, lo_out);
        end
        @(posedge clk); #1;
        cmp_cnt++;
        if (busy !== 1'b0) begin err_cnt++; $display("FAIL cancel_start_dropped: got %b expected 0", busy); end
        cancel = 1'b1; mt_en = 1'b1; mt_sel = 1'b0; rs_val = 32'h55;
        @(posedge clk); #1;
        cancel = 1'b0; mt_en = 1'b0;
        cmp_cnt++;
        if (hi_out !== 32'hAA) begin err_cnt++; $display("FAIL cancel_mt_dropped: got %h expected aa", hi_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_mt_mf();
        test_back_to_back();
        test_reset_mid();
`ifdef MDU_CANCEL_EN
        test_cancel();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
